// File: rtl/mux_arb_pkg.sv
// Shared types for the round-robin muxed arbiter: output FSM states and mux select encodings.
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD_A = 2'd1,
        HOLD_B = 2'd2
    } state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Handshake bundle for mux_rr_arbiter: two requester channels in, one consumer channel out.
// The a_last/b_last packet markers exist only when MUX_ARB_LOCK_EN is defined.
interface mux_rr_arbiter_if #(
    parameter int WIDTH = 4
);
    logic             a_valid;
    logic [WIDTH-1:0] a_data;
    logic             a_ready;
    logic             b_valid;
    logic [WIDTH-1:0] b_data;
    logic             b_ready;
    logic             x_valid;
    logic [WIDTH-1:0] x_data;
    logic             x_sel;
    logic             x_ready;
`ifdef MUX_ARB_LOCK_EN
    logic             a_last;
    logic             b_last;

    // master: the surrounding producers and consumer; slave: the arbiter
    modport master (
        output a_valid, a_data, a_last, b_valid, b_data, b_last, x_ready,
        input  a_ready, b_ready, x_valid, x_data, x_sel
    );
    modport slave (
        input  a_valid, a_data, a_last, b_valid, b_data, b_last, x_ready,
        output a_ready, b_ready, x_valid, x_data, x_sel
    );
`else
    modport master (
        output a_valid, a_data, b_valid, b_data, x_ready,
        input  a_ready, b_ready, x_valid, x_data, x_sel
    );
    modport slave (
        input  a_valid, a_data, b_valid, b_data, x_ready,
        output a_ready, b_ready, x_valid, x_data, x_sel
    );
`endif
endinterface

// File: rtl/mux_rr_arbiter_pick.sv
// rr_pick2: combinational two-way round-robin picker; on a tie the source
// that was not granted last wins.
module rr_pick2
    import mux_arb_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last_sel,
    output logic grant,
    output logic grant_any
);

    always_comb begin
        grant = SEL_A;
        if (req_a && req_b) begin
            grant = ~last_sel;
        end else if (req_b) begin
            grant = SEL_B;
        end
        grant_any = req_a || req_b;
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Two requesters share one 2:1 mux into a registered valid/ready output stage.
// Define MUX_ARB_LOCK_EN to hold the grant for a whole packet (a_last/b_last).
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    mux_rr_arbiter_if.slave bus
);

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] data_p1;
    logic             sel_p1;
    logic             last_sel;
    logic             load;
    logic             accept;
    logic             req_a;
    logic             req_b;
    logic             grant;
    logic             grant_any;
    logic [WIDTH-1:0] mux_data;

    // A new word may enter whenever the register is empty or draining this cycle.
    assign load = (state == IDLE) || bus.x_ready;

`ifdef MUX_ARB_LOCK_EN
    logic lock_q;
    logic lock_src;
    logic grant_last;

    // While a packet is open the other requester is masked, even if the owner idles.
    assign req_a      = bus.a_valid && !(lock_q && (lock_src == SEL_B));
    assign req_b      = bus.b_valid && !(lock_q && (lock_src == SEL_A));
    assign grant_last = (grant == SEL_B) ? bus.b_last : bus.a_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q   <= 1'b0;
            lock_src <= SEL_A;
        end else if (accept) begin
            lock_q   <= !grant_last;
            lock_src <= grant;
        end
    end
`else
    assign req_a = bus.a_valid;
    assign req_b = bus.b_valid;
`endif

    rr_pick2 u_pick (
        .req_a     (req_a),
        .req_b     (req_b),
        .last_sel  (last_sel),
        .grant     (grant),
        .grant_any (grant_any)
    );

    assign accept      = load && grant_any;
    assign bus.a_ready = accept && (grant == SEL_A);
    assign bus.b_ready = accept && (grant == SEL_B);
    assign mux_data    = (grant == SEL_B) ? bus.b_data : bus.a_data;

    // ---- p1: output register stage ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        if (load) begin
            if (grant_any) begin
                state_n = (grant == SEL_B) ? HOLD_B : HOLD_A;
            end else begin
                state_n = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_p1  <= '0;
            sel_p1   <= SEL_A;
            last_sel <= SEL_B;
        end else if (accept) begin
            data_p1 <= mux_data;
            sel_p1  <= grant;
`ifdef MUX_ARB_LOCK_EN
            if (grant_last) begin
                last_sel <= grant;
            end
`else
            last_sel <= grant;
`endif
        end
    end

    always_comb begin
        bus.x_valid = 1'b0;
        bus.x_sel   = sel_p1;
        bus.x_data  = data_p1;
        case (state)
            HOLD_A: begin
                bus.x_valid = 1'b1;
                bus.x_sel   = SEL_A;
            end
            HOLD_B: begin
                bus.x_valid = 1'b1;
                bus.x_sel   = SEL_B;
            end
            default: begin
                bus.x_valid = 1'b0;
            end
        endcase
    end

endmodule
